// File: rtl/mips_lsu_pkg.sv
// Shared types for the MIPS load/store unit: operation codes, FSM states
// and access-size helpers used by both the top level and the lane steering.
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    LW  = 4'd0,
    LH  = 4'd1,
    LHU = 4'd2,
    LB  = 4'd3,
    LBU = 4'd4,
    SW  = 4'd5,
    SH  = 4'd6,
    SB  = 4'd7,
    LWL = 4'd8,
    LWR = 4'd9
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  // Unknown codes report word size; they never reach the bus anyway.
  function automatic lsu_size_t op_size(input logic [3:0] op);
    case (op)
      LB, LBU, SB:  return SZ_BYTE;
      LH, LHU, SH:  return SZ_HALF;
      default:      return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Combinational byte-lane steering: byteenable/writedata generation for
// stores and extraction, extension and LWL/LWR merging for loads.
module mips_lsu_lane
  import mips_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [3:0]        op,
  input  logic [OFF_W-1:0]  off,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rt,
  input  logic [DATA_W-1:0] rdata_bus,
  output logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] writedata,
  output logic [31:0]       rdata
);

  lsu_size_t        size;
  logic [BE_W-1:0]  mask;
  logic [OFF_W-1:0] lane_off;
  logic [31:0]      word;
  logic [1:0]       b;
  logic [4:0]       sh;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  always_comb begin
    size      = op_size(op);
    mask      = BE_W'(4'hF);
    writedata = {(DATA_W/32){wdata}};
    case (size)
      SZ_BYTE: begin
        mask      = BE_W'(1);
        writedata = {BE_W{wdata[7:0]}};
      end
      SZ_HALF: begin
        mask      = BE_W'(3);
        writedata = {(BE_W/2){wdata[15:0]}};
      end
      default: begin
        mask      = BE_W'(4'hF);
        writedata = {(DATA_W/32){wdata}};
      end
    endcase
    // Word accesses (including unaligned LWL/LWR) always cover a whole aligned word.
    lane_off   = (size == SZ_WORD) ? (off & ~OFF_W'(3)) : off;
    byteenable = mask << lane_off;
  end

  if (DATA_W == 64) begin : g_sel64
    assign word = off[2] ? rdata_bus[63:32] : rdata_bus[31:0];
  end else begin : g_sel32
    assign word = rdata_bus[31:0];
  end

  assign b      = off[1:0];
  assign sh     = {b, 3'b000};
  assign byte_v = 8'(word >> sh);
  assign half_v = 16'(word >> sh);

  always_comb begin
    rdata = 32'd0;
    case (op)
      LW:  rdata = word;
      LH:  rdata = {{16{half_v[15]}}, half_v};
      LHU: rdata = {16'd0, half_v};
      LB:  rdata = {{24{byte_v[7]}}, byte_v};
      LBU: rdata = {24'd0, byte_v};
      // The extra >>8 makes b=3 keep no rt bits without a 32-bit shift amount.
      LWL: rdata = (word << {~b, 3'b000}) | (rt & ((32'hFFFF_FFFF >> sh) >> 8));
      LWR: rdata = (word >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// Load/store unit bridging the multicycle MIPS core to an Avalon-MM master.
// Define MIPS_LSU_LWLR_EN to accept LWL/LWR; otherwise they return an error.
module mips_bus_lsu
  import mips_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [31:0]           req_rt,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  input  logic                  waitrequest,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  lsu_state_t        state_reg;
  logic [3:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rt_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              read_reg;
  logic              write_reg;
  logic [31:0]       stall_reg;
  logic [31:0]       stall_next;
  logic              req_ok;

  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wd;
  logic [31:0]       lane_rdata;

  always_comb begin
    req_ok = 1'b0;
    case (req_op)
      LW, SW:       req_ok = (req_addr[1:0] == 2'b00);
      LH, LHU, SH:  req_ok = ~req_addr[0];
      LB, LBU, SB:  req_ok = 1'b1;
`ifdef MIPS_LSU_LWLR_EN
      LWL, LWR:     req_ok = 1'b1;
`else
      LWL, LWR:     req_ok = 1'b0;
`endif
      default:      req_ok = 1'b0;
    endcase
  end

  assign stall_next = stall_reg + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= 4'd0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      rt_reg    <= 32'd0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      stall_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg    <= req_op;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            rt_reg    <= req_rt;
            rdata_reg <= '0;
            stall_reg <= 32'd0;
            if (req_ok) begin
              state_reg <= BUS;
              err_reg   <= 1'b0;
              read_reg  <= ~is_store(req_op);
              write_reg <= is_store(req_op);
            end else begin
              state_reg <= RESP;
              err_reg   <= 1'b1;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            rdata_reg <= readdata;
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            state_reg <= RESP;
          end else begin
            stall_reg <= stall_next;
            // Abort on the edge at which the stalled-cycle count reaches TIMEOUT.
            if (TIMEOUT != 0 && stall_next == 32'(TIMEOUT)) begin
              read_reg  <= 1'b0;
              write_reg <= 1'b0;
              err_reg   <= 1'b1;
              state_reg <= RESP;
            end
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  mips_lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .op         (op_reg),
    .off        (addr_reg[OFF_W-1:0]),
    .wdata      (wdata_reg),
    .rt         (rt_reg),
    .rdata_bus  (rdata_reg),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .rdata      (lane_rdata)
  );

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_err   = resp_valid & err_reg;
  assign resp_rdata = (resp_valid && !err_reg && !is_store(op_reg)) ? lane_rdata : 32'd0;
  assign read       = read_reg;
  assign write      = write_reg;
  assign address    = (state_reg == BUS) ? {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign byteenable = (state_reg == BUS) ? lane_be : '0;
  assign writedata  = write_reg ? lane_wd : '0;

endmodule

// File: doc/mips_bus_lsu.md
# mips_bus_lsu

Parametrised load/store unit between the multicycle MIPS core FSM and the Avalon memory-mapped master port. It accepts one request at a time from the core and performs all byte-lane steering, byteenable generation, sign/zero extension and alignment checking. It holds read/write across waitrequest stalls and aborts hung transfers with a timeout. It replaces the ad-hoc address/read/write/writedata wiring in the CPU top level. Instruction fetch uses it as a plain LW.

## Interface
Parameters:
- DATA_W, 32, Avalon data width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 0, maximum number of stalled cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock. One clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  unit can accept a request.
- req_op  in  4  operation code, type lsu_op_t.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rt  in  32  old rt value, used only for LWL/LWR merging.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended or merged load result; 0 for stores.
- resp_err  out  1  misaligned, illegal op, or timeout; valid with resp_valid.
- address  out  ADDR_W  Avalon address, aligned to DATA_W/8.
- read, write  out  1  Avalon strobes.
- waitrequest  in  1  Avalon stall.
- writedata  out  DATA_W  lane-steered store data.
- byteenable  out  DATA_W/8  active byte lanes.
- readdata  in  DATA_W  Avalon read data; valid in the cycle waitrequest is low.

## Operation
- The FSM has three states: IDLE, BUS, RESP. Reset puts it in IDLE. During reset all outputs are 0 except req_ready, which is 1.
- IDLE: req_ready=1. On req_valid the unit latches op, addr, wdata and rt.
  - Legal and aligned request: go to BUS.
  - Otherwise: go to RESP with err=1 and no bus access.
- BUS: read or write is held at 1, with address, writedata and byteenable held stable.
  - waitrequest=0: capture readdata, go to RESP.
  - waitrequest=1: increment the stall counter. If TIMEOUT≠0 and the counter reaches TIMEOUT, drop the strobes and go to RESP with err=1.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
- Byte order is little-endian: byte offset k lives on data bits [8k+7:8k].
- Lane selection: off = addr[log2(DATA_W/8)-1:0]. With DATA_W=64, addr[2] selects the 32-bit half.
- LW, SW: word access, byteenable 4'b1111 (shifted to the selected half when DATA_W=64). Require addr[1:0]=0.
- LH, LHU, SH: halfword access, 2 enabled lanes. Require addr[0]=0. LH sign-extends; LHU zero-extends.
- LB, LBU, SB: byte access, 1 enabled lane. LB sign-extends; LBU zero-extends.
- Stores replicate data across lanes. Lanes that are not enabled carry don't-care data.
- Unknown req_op codes: err=1.

## Timing
- Minimum latency: request accepted at edge N, read/write asserted in cycle N+1, resp_valid in cycle N+2 when waitrequest=0.
- Each stalled cycle adds one cycle of latency.
- An error response with no bus access has resp_valid in cycle N+1.
- req_ready=0 in BUS and RESP. A req_valid arriving then is ignored; the core must hold it.
- The Avalon strobes are registered and never glitch. Exactly one of read/write is high, and only in BUS.
- Timeout: the abort happens at the edge where the stall count equals TIMEOUT; resp_valid follows in the next cycle.
- Reset mid-transfer: the strobes drop at the next edge, no response is issued, and the stall counter clears.

## Configuration
- MIPS_LSU_LWLR_EN defined: LWL and LWR are supported. Each performs an aligned word read with all 4 lanes enabled, b = addr[1:0], alignment unchecked.
  - LWL: result = (mem << 8(3−b)) | (rt & (32'hFFFFFFFF >> 8(b+1))). When b=3, no rt bits are kept.
  - LWR: result = (mem >> 8b) | (rt & ~(32'hFFFFFFFF >> 8b)).
- MIPS_LSU_LWLR_EN undefined: LWL and LWR are illegal ops, return err=1, and make no bus access.

## Structure
- Package mips_lsu_pkg holds:
  - lsu_op_t with encodings LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7, LWL=8, LWR=9;
  - the state enum;
  - a function returning the access size for an op.
- Sub-module mips_lsu_lane is purely combinational:
  - store side: op + offset → byteenable and writedata;
  - load side: captured readdata + op + offset + rt → resp_rdata.
- The top module holds the FSM, request latches and stall counter.

## Test plan
- LW at 0x1000, readdata 0xDEADBEEF, waitrequest=0 → read for 1 cycle, address 0x1000, resp_rdata 0xDEADBEEF, err=0, resp_valid at N+2.
- LB at 0x1003 with readdata 0x80000000 → byteenable 4'b1000, resp 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH 0x1234 at 0x2002 with 3 waitrequest cycles → write held 4 cycles, byteenable 4'b1100, writedata[31:16]=0x1234, resp_valid at N+5.
- LW at 0x1001, and LH at 0x1003 → resp_err=1 at N+1, read and write never asserted.
- TIMEOUT=4, waitrequest stuck at 1 → read drops after 4 stalled cycles, resp_err=1. Reset asserted during BUS → read low after the next edge, req_ready=1.
- With MIPS_LSU_LWLR_EN: LWL at 0x1001, mem 0x44332211, rt 0xAABBCCDD → 0x2211CCDD. LWR at 0x1001 → 0xAA443322. Without the macro → err=1.
